// File: rtl/mazegen_rect.sv
// Rectangular maze generator: randomised depth-first search over a W x H cell grid
// using an explicit stack and a 16-bit LFSR. The finished grid is read one row per cycle.
module mazegen_rect #(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int RW = $clog2(2*H+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   seed,
  output logic          busy,
  output logic          done,
  input  logic [RW-1:0] rd_row,
  output logic [2*W:0]  rd_data
);

  localparam int N   = W * H;
  localparam int GR  = 2 * H + 1;
  localparam int CW  = $clog2(2 * W + 1);
  localparam int XW  = (W > 1) ? $clog2(W) : 1;
  localparam int YW  = (H > 1) ? $clog2(H) : 1;
  localparam int CIW = (N > 1) ? $clog2(N) : 1;
  localparam int SPW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_INIT, S_CHECK, S_CARVE, S_POP, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      lfsr_reg;
  logic [SPW-1:0]   sp_reg;
  logic [RW-1:0]    clr_reg;
  logic [XW-1:0]    sel_x_reg;
  logic [YW-1:0]    sel_y_reg;
  logic             entry_done_reg, exit_done_reg;

  logic [2*W:0]     grid_mem [0:GR-1];
  logic [N-1:0]     visited_reg;
  logic [XW-1:0]    stk_x_mem [0:N-1];
  logic [YW-1:0]    stk_y_mem [0:N-1];

  logic             start_ok;
  logic             lfsr_fb;
  logic [CIW-1:0]   top_idx, push_idx, init_idx, new_idx;
  int               cx, cy, sx, sy, nx, ny, ncnt, pick, sel, seen, open_y;
  int               nbx [4];
  int               nby [4];
  logic             nvalid [4];
  logic [RW-1:0]    init_row, wall_row, new_row;
  logic [CW-1:0]    init_col, wall_col, new_col, open_col;
  logic             entry_fire, exit_fire;

  assign start_ok = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign lfsr_fb  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done     = (state_reg == S_DONE);

  // Neighbour scan of the cell on top of the stack and carve geometry.
  always_comb begin
    top_idx  = CIW'(sp_reg - 1'b1);
    push_idx = CIW'(sp_reg);
    cx       = int'(stk_x_mem[top_idx]);
    cy       = int'(stk_y_mem[top_idx]);
    sx       = int'(lfsr_reg[7:0]) % W;
    sy       = int'(lfsr_reg[15:8]) % H;
    nbx      = '{cx, cx, cx + 1, cx - 1};
    nby      = '{cy - 1, cy + 1, cy, cy};
    nvalid   = '{default: 1'b0};
    if (cy > 0)     nvalid[0] = !visited_reg[CIW'(nby[0] * W + nbx[0])];
    if (cy < H - 1) nvalid[1] = !visited_reg[CIW'(nby[1] * W + nbx[1])];
    if (cx < W - 1) nvalid[2] = !visited_reg[CIW'(nby[2] * W + nbx[2])];
    if (cx > 0)     nvalid[3] = !visited_reg[CIW'(nby[3] * W + nbx[3])];
    ncnt = 0;
    for (int i = 0; i < 4; i++) if (nvalid[i]) ncnt = ncnt + 1;
    pick = (ncnt > 0) ? int'(lfsr_reg[7:0]) % ncnt : 0;
    sel  = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (nvalid[i]) begin
        if (seen == pick) sel = i;
        seen = seen + 1;
      end
    end
    nx       = int'(sel_x_reg);
    ny       = int'(sel_y_reg);
    init_row = RW'(2 * sy + 1);
    init_col = CW'(2 * sx + 1);
    init_idx = CIW'(sy * W + sx);
    wall_row = RW'(cy + ny + 1);
    wall_col = CW'(cx + nx + 1);
    new_row  = RW'(2 * ny + 1);
    new_col  = CW'(2 * nx + 1);
    new_idx  = CIW'(ny * W + nx);
    open_col = (state_reg == S_INIT) ? init_col : new_col;
    open_y   = (state_reg == S_INIT) ? sy : ny;
    // In INIT the flags are being re-armed, so only the cell position matters.
    entry_fire = (open_y == 0) &&
                 (state_reg == S_INIT || (state_reg == S_CARVE && !entry_done_reg));
    exit_fire  = (open_y == H - 1) &&
                 (state_reg == S_INIT || (state_reg == S_CARVE && !exit_done_reg));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_CLEAR;
      S_CLEAR:        if (clr_reg == RW'(2 * H)) state_next = S_INIT;
      S_INIT:         state_next = S_CHECK;
      S_CHECK:        state_next = (ncnt > 0) ? S_CARVE : S_POP;
      S_CARVE:        state_next = S_CHECK;
      S_POP:          state_next = (sp_reg == SPW'(1)) ? S_DONE : S_CHECK;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      lfsr_reg       <= 16'hACE1;
      sp_reg         <= '0;
      clr_reg        <= '0;
      sel_x_reg      <= '0;
      sel_y_reg      <= '0;
      entry_done_reg <= 1'b0;
      exit_done_reg  <= 1'b0;
      rd_data        <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) lfsr_reg <= (seed == 16'h0000) ? 16'hACE1 : seed;
      else          lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
      rd_data <= (rd_row <= RW'(2 * H)) ? grid_mem[rd_row] : '0;
      if (start_ok) clr_reg <= '0;
      case (state_reg)
        S_CLEAR: clr_reg <= clr_reg + 1'b1;
        S_INIT: begin
          sp_reg         <= SPW'(1);
          entry_done_reg <= (sy == 0);
          exit_done_reg  <= (sy == H - 1);
        end
        S_CHECK: begin
          sel_x_reg <= XW'(nbx[sel]);
          sel_y_reg <= YW'(nby[sel]);
        end
        S_CARVE: begin
          sp_reg <= sp_reg + 1'b1;
          if (entry_fire) entry_done_reg <= 1'b1;
          if (exit_fire)  exit_done_reg  <= 1'b1;
        end
        S_POP: sp_reg <= sp_reg - 1'b1;
        default: ;
      endcase
    end
  end

  // Grid, visited set and stack carry no reset; CLEAR and INIT rebuild them.
  always_ff @(posedge clk) begin
    case (state_reg)
      S_CLEAR: grid_mem[clr_reg] <= '1;
      S_INIT: begin
        visited_reg                <= '0;
        visited_reg[init_idx]      <= 1'b1;
        grid_mem[init_row][init_col] <= 1'b0;
        stk_x_mem[0]               <= XW'(sx);
        stk_y_mem[0]               <= YW'(sy);
      end
      S_CARVE: begin
        visited_reg[new_idx]         <= 1'b1;
        grid_mem[wall_row][wall_col] <= 1'b0;
        grid_mem[new_row][new_col]   <= 1'b0;
        stk_x_mem[push_idx]          <= sel_x_reg;
        stk_y_mem[push_idx]          <= sel_y_reg;
      end
      default: ;
    endcase
    if (entry_fire) grid_mem[0][open_col]            <= 1'b0;
    if (exit_fire)  grid_mem[RW'(2 * H)][open_col]   <= 1'b0;
  end

endmodule

// File: tb/tb_mazegen_rect.sv
// Bench for mazegen_rect: three grid sizes, latency, structural maze properties,
// determinism, handshake and reset behaviour.
module tb_mazegen_rect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st [3];
  logic [15:0] sd [3];
  logic [4:0]  rr [3];
  logic        bs [3];
  logic        dn [3];
  logic [2:0]  rd0;
  logic [16:0] rd1;
  logic [10:0] rd2;

  int wt [3] = '{1, 8, 5};
  int ht [3] = '{1, 8, 3};

  mazegen_rect #(.W(1), .H(1)) u_1x1 (
    .clk(clk), .rst(rst), .start(st[0]), .seed(sd[0]), .busy(bs[0]), .done(dn[0]),
    .rd_row(rr[0][1:0]), .rd_data(rd0));
  mazegen_rect #(.W(8), .H(8)) u_8x8 (
    .clk(clk), .rst(rst), .start(st[1]), .seed(sd[1]), .busy(bs[1]), .done(dn[1]),
    .rd_row(rr[1][4:0]), .rd_data(rd1));
  mazegen_rect #(.W(5), .H(3)) u_5x3 (
    .clk(clk), .rst(rst), .start(st[2]), .seed(sd[2]), .busy(bs[2]), .done(dn[2]),
    .rd_row(rr[2][2:0]), .rd_data(rd2));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          row;
    bit          chk;
    logic [16:0] exp;
  } rd_t;
  rd_t sb [$];

  typedef struct {
    int          k;
    logic [15:0] seed;
    bit          rowchk;
    logic [16:0] rowexp;
  } vec_t;
  vec_t vt [5];

  logic [16:0] g     [0:16];
  logic [16:0] saved [0:16];

  function automatic logic [16:0] rd_sel(int k);
    case (k)
      0:       return {14'b0, rd0};
      1:       return rd1;
      default: return {6'b0, rd2};
    endcase
  endfunction

  function automatic int lat(int k);
    return (2 * ht[k] + 1) + 1 + 2 * (2 * wt[k] * ht[k] - 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive a row address, queue the expectation, compare one cycle later.
  task automatic read_row(int k, int r, bit c, logic [16:0] e);
    rd_t item;
    rr[k] = 5'(r);
    sb.push_back('{row: r, chk: c, exp: e});
    @(posedge clk); #1;
    item = sb.pop_front();
    if (item.row <= 16) g[item.row] = rd_sel(k);
    if (item.chk) chk($sformatf("rd_row%0d", item.row), 32'(rd_sel(k)), 32'(item.exp));
    $display("[TB] read k=%0d row=%0d data=%0h", k, item.row, rd_sel(k));
  endtask

  task automatic read_grid(int k, bit c, logic [16:0] e);
    for (int r = 0; r <= 2 * ht[k]; r++) read_row(k, r, c, e);
  endtask

  task automatic run(int k, logic [15:0] s, bit hold, output int cyc);
    st[k] = 1'b1;
    sd[k] = s;
    @(posedge clk); #1;
    if (!hold) st[k] = 1'b0;
    chk("busy_after_start", 32'(bs[k]), 32'd1);
    chk("done_after_start", 32'(dn[k]), 32'd0);
    cyc = 0;
    while (!dn[k] && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    st[k] = 1'b0;
    chk("busy_at_done", 32'(bs[k]), 32'd0);
    $display("[TB] run k=%0d seed=%04h latency=%0d", k, s, cyc);
  endtask

  task automatic check_maze(int w, int h);
    int bad, side, z0, zb, c0, ce, opn, cells, p, r, c, nr, nc;
    int dr [4] = '{-1, 1, 0, 0};
    int dc [4] = '{0, 0, 1, -1};
    bit sn [0:16][0:16];
    int q [$];
    bad = 0; side = 0; z0 = 0; zb = 0; c0 = 0; ce = 0; opn = 0; cells = 0;
    for (int i = 0; i <= 2 * h; i += 2)
      for (int j = 0; j <= 2 * w; j += 2)
        if (g[i][j] !== 1'b1) bad++;
    chk("posts", 32'(bad), 32'd0);
    for (int i = 0; i <= 2 * h; i++)
      if (g[i][0] !== 1'b1 || g[i][2 * w] !== 1'b1) side++;
    chk("side_walls", 32'(side), 32'd0);
    for (int j = 0; j <= 2 * w; j++) begin
      if (g[0][j] === 1'b0)     begin z0++; c0 = j; end
      if (g[2 * h][j] === 1'b0) begin zb++; ce = j; end
    end
    chk("entry_count", 32'(z0), 32'd1);
    chk("exit_count", 32'(zb), 32'd1);
    for (int i = 1; i < 2 * h; i++)
      for (int j = 1; j < 2 * w; j++)
        if (((i + j) % 2 == 1) && g[i][j] === 1'b0) opn++;
    chk("openings", 32'(opn), 32'(w * h - 1));
    for (int i = 0; i <= 16; i++)
      for (int j = 0; j <= 16; j++) sn[i][j] = 1'b0;
    sn[0][c0] = 1'b1;
    q.push_back(c0);
    while (q.size() > 0) begin
      p = q.pop_front();
      r = p / 32;
      c = p % 32;
      if ((r % 2 == 1) && (c % 2 == 1)) cells++;
      for (int d = 0; d < 4; d++) begin
        nr = r + dr[d];
        nc = c + dc[d];
        if (nr >= 0 && nr <= 2 * h && nc >= 0 && nc <= 2 * w)
          if (!sn[nr][nc] && g[nr][nc] === 1'b0) begin
            sn[nr][nc] = 1'b1;
            q.push_back(nr * 32 + nc);
          end
      end
    end
    chk("bfs_cells", 32'(cells), 32'(w * h));
    chk("exit_reached", 32'(sn[2 * h][ce]), 32'd1);
  endtask

  function automatic int grid_diff(int k);
    int d = 0;
    for (int r = 0; r <= 2 * ht[k]; r++) if (g[r] !== saved[r]) d++;
    return d;
  endfunction

  initial begin
    int cyc, seen_done;
    vt[0] = '{k: 0, seed: 16'h0001, rowchk: 1'b1, rowexp: 17'b101};
    vt[1] = '{k: 1, seed: 16'h0001, rowchk: 1'b0, rowexp: 17'b0};
    vt[2] = '{k: 1, seed: 16'hBEEF, rowchk: 1'b0, rowexp: 17'b0};
    vt[3] = '{k: 1, seed: 16'h1234, rowchk: 1'b0, rowexp: 17'b0};
    vt[4] = '{k: 2, seed: 16'h00FF, rowchk: 1'b0, rowexp: 17'b0};
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; sd[k] = 16'h0; rr[k] = 5'h0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    #20;
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", 32'(bs[k]), 32'd0);
      chk("reset_done", 32'(dn[k]), 32'd0);
      chk("reset_rd_data", 32'(rd_sel(k)), 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run(vt[i].k, vt[i].seed, 1'b0, cyc);
      chk($sformatf("latency_v%0d", i), 32'(cyc), 32'(lat(vt[i].k)));
      read_grid(vt[i].k, vt[i].rowchk, vt[i].rowexp);
      check_maze(wt[vt[i].k], ht[vt[i].k]);
    end
    chk("latency_1x1_const", 32'(lat(0)), 32'd6);

    // Same seed twice; the second start also arrives while done is high.
    run(1, 16'h5A5A, 1'b0, cyc);
    read_grid(1, 1'b0, 17'b0);
    for (int r = 0; r <= 16; r++) saved[r] = g[r];
    run(1, 16'h5A5A, 1'b0, cyc);
    chk("restart_latency", 32'(cyc), 32'd272);
    read_grid(1, 1'b0, 17'b0);
    chk("determinism", 32'(grid_diff(1)), 32'd0);

    run(1, 16'h0000, 1'b0, cyc);
    read_grid(1, 1'b0, 17'b0);
    check_maze(8, 8);
    for (int r = 0; r <= 16; r++) saved[r] = g[r];
    run(1, 16'hACE1, 1'b0, cyc);
    read_grid(1, 1'b0, 17'b0);
    chk("seed0_equals_ace1", 32'(grid_diff(1)), 32'd0);

    run(2, 16'h00FF, 1'b1, cyc);
    chk("held_start_latency", 32'(cyc), 32'd66);
    read_row(2, 7, 1'b1, 17'b0);
    read_row(2, 0, 1'b0, 17'b0);

    // Abort a run with reset and make sure nothing completes afterwards.
    st[1] = 1'b1;
    sd[1] = 16'h1234;
    @(posedge clk); #1;
    st[1] = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrun_reset_busy", 32'(bs[1]), 32'd0);
    chk("midrun_reset_done", 32'(dn[1]), 32'd0);
    chk("midrun_reset_rd_data", 32'(rd1), 32'd0);
    @(negedge clk) rst = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (dn[1] || bs[1]) seen_done++;
    end
    chk("no_done_after_reset", 32'(seen_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
